// File: rtl/rtype_exec_pipe.sv
// Two-stage MIPS R-type execute pipe: 32-entry register file, operand forwarding, 13-op ALU.
// Optional build macro RTYPE_OVF_TRAP_EN: signed-overflow trap on ADD/SUB that suppresses writeback.
module rtype_exec_pipe #(
    parameter int DATA_W        = 32,
    parameter int REG_INIT_MODE = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    output logic              out_ovf,
    output logic [4:0]        ra,
    output logic [4:0]        rb,
    output logic [4:0]        rw,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] busW
);

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [6:0] LP_W7   = 7'(DATA_W);

    // Decode of the incoming instruction
    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [4:0] w_shamt;
    logic [5:0] w_funct;
    logic       w_legal;

    assign w_opcode = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_shamt  = instr[10:6];
    assign w_funct  = instr[5:0];

    always_comb begin
        w_legal = 1'b0;
        if (w_opcode == 6'd0) begin
            case (w_funct)
                FN_SLL, FN_SRL, FN_SRA,
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                FN_AND, FN_OR, FN_XOR, FN_NOR,
                FN_SLT, FN_SLTU: w_legal = 1'b1;
                default:         w_legal = 1'b0;
            endcase
        end
    end

    // Stage 1 registers
    logic              r_s1_valid;
    logic              r_s1_legal;
    logic [4:0]        r_s1_rs;
    logic [4:0]        r_s1_rt;
    logic [4:0]        r_s1_rd;
    logic [4:0]        r_s1_shamt;
    logic [5:0]        r_s1_funct;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;

    logic              w_ovf;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_sh_big;

    // Register file; entry 0 is hard-wired to zero so it never needs a write guard on reads
    logic [DATA_W-1:0] w_rf [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign w_rf[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        r_q <= (REG_INIT_MODE == 1) ? DATA_W'(gi) : '0;
                    end else if (w_wr_en && (r_s1_rd == 5'(gi))) begin
                        r_q <= busW;
                    end
                end
                assign w_rf[gi] = r_q;
            end
        end
    endgenerate

    // Forward the result retiring at this edge when it targets a register being read
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign w_fwd_a = w_wr_en && (r_s1_rd == w_rs);
    assign w_fwd_b = w_wr_en && (r_s1_rd == w_rt);
    assign w_op_a  = w_fwd_a ? busW : w_rf[w_rs];
    assign w_op_b  = w_fwd_b ? busW : w_rf[w_rt];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_legal <= 1'b0;
            r_s1_rs    <= '0;
            r_s1_rt    <= '0;
            r_s1_rd    <= '0;
            r_s1_shamt <= '0;
            r_s1_funct <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_legal <= w_legal;
                r_s1_rs    <= w_rs;
                r_s1_rt    <= w_rt;
                r_s1_rd    <= w_rd;
                r_s1_shamt <= w_shamt;
                r_s1_funct <= w_funct;
                r_s1_a     <= w_op_a;
                r_s1_b     <= w_op_b;
            end
        end
    end

    // ALU on the stage-1 operands
    assign w_sum    = r_s1_a + r_s1_b;
    assign w_diff   = r_s1_a - r_s1_b;
    assign w_sh_big = ({2'b00, r_s1_shamt} >= LP_W7);

    always_comb begin
        w_alu = '0;
        case (r_s1_funct)
            FN_ADD, FN_ADDU: w_alu = w_sum;
            FN_SUB, FN_SUBU: w_alu = w_diff;
            FN_AND:          w_alu = r_s1_a & r_s1_b;
            FN_OR:           w_alu = r_s1_a | r_s1_b;
            FN_XOR:          w_alu = r_s1_a ^ r_s1_b;
            FN_NOR:          w_alu = ~(r_s1_a | r_s1_b);
            FN_SLT:          w_alu = DATA_W'($signed(r_s1_a) < $signed(r_s1_b));
            FN_SLTU:         w_alu = DATA_W'(r_s1_a < r_s1_b);
            FN_SLL:          w_alu = w_sh_big ? '0 : (r_s1_b << r_s1_shamt);
            FN_SRL:          w_alu = w_sh_big ? '0 : (r_s1_b >> r_s1_shamt);
            FN_SRA:          w_alu = w_sh_big ? {DATA_W{r_s1_b[DATA_W-1]}}
                                              : DATA_W'($signed(r_s1_b) >>> r_s1_shamt);
            default:         w_alu = '0;
        endcase
    end

    assign busW = r_s1_legal ? w_alu : '0;

`ifdef RTYPE_OVF_TRAP_EN
    // SUB overflows when A and -B share a sign, i.e. A and B differ in sign
    always_comb begin
        w_ovf = 1'b0;
        if (r_s1_legal && (r_s1_funct == FN_ADD)) begin
            w_ovf = (r_s1_a[DATA_W-1] == r_s1_b[DATA_W-1]) &&
                    (w_sum[DATA_W-1] != r_s1_a[DATA_W-1]);
        end else if (r_s1_legal && (r_s1_funct == FN_SUB)) begin
            w_ovf = (r_s1_a[DATA_W-1] != r_s1_b[DATA_W-1]) &&
                    (w_diff[DATA_W-1] != r_s1_a[DATA_W-1]);
        end
    end
`else
    assign w_ovf = 1'b0;
`endif

    assign w_wr_en = r_s1_valid && r_s1_legal && !w_ovf && (r_s1_rd != 5'd0);

    // Retire register; payload holds through bubbles
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
            out_ovf     <= 1'b0;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_result  <= busW;
                out_rd      <= r_s1_rd;
                out_illegal <= !r_s1_legal;
                out_ovf     <= w_ovf;
            end
        end
    end

    assign ra   = r_s1_rs;
    assign rb   = r_s1_rt;
    assign rw   = r_s1_rd;
    assign busA = r_s1_a;
    assign busB = r_s1_b;

endmodule

// File: tb/tb_rtype_exec_pipe.sv
// Directed bench for rtype_exec_pipe: expected retirements are queued at issue and checked on out_valid.
module tb_rtype_exec_pipe;

    localparam int DW = 32;
`ifdef RTYPE_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   instr = '0;
    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [4:0]    out_rd;
    logic          out_illegal;
    logic          out_ovf;
    logic [4:0]    ra, rb, rw;
    logic [DW-1:0] busA, busB, busW;

    always #5 CLK = ~CLK;

    rtype_exec_pipe #(.DATA_W(DW), .REG_INIT_MODE(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .instr(instr),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
        .out_illegal(out_illegal), .out_ovf(out_ovf),
        .ra(ra), .rb(rb), .rw(rw), .busA(busA), .busB(busB), .busW(busW)
    );

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          last_rst = 1'b1;
    logic [31:0] prev_res = '0;
    logic [4:0]  prev_rd = '0;

    function automatic logic [31:0] enc(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        exp_t it;
        if (last_rst) begin
            chk("rst_valid",  64'(out_valid), 64'd0);
            chk("rst_result", 64'(out_result), 64'd0);
            chk("rst_rd",     64'(out_rd), 64'd0);
            chk("rst_ill",    64'(out_illegal), 64'd0);
            chk("rst_ovf",    64'(out_ovf), 64'd0);
            chk("rst_busA",   64'(busA), 64'd0);
            chk("rst_busB",   64'(busB), 64'd0);
            chk("rst_busW",   64'(busW), 64'd0);
            chk("rst_ra_rb_rw", 64'({ra, rb, rw}), 64'd0);
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                it = sb.pop_front();
                $display("retire cyc=%0d rd=%0d result=%08h ill=%0b ovf=%0b",
                         cyc, out_rd, out_result, out_illegal, out_ovf);
                chk("latency", 64'(cyc), 64'(it.cyc + 2));
                chk("result",  64'(out_result), 64'(it.res));
                chk("rd",      64'(out_rd), 64'(it.rd));
                chk("illegal", 64'(out_illegal), 64'(it.ill));
                chk("ovf",     64'(out_ovf), 64'(it.ovf));
            end
        end else begin
            chk("hold_result", 64'(out_result), 64'(prev_res));
            chk("hold_rd",     64'(out_rd), 64'(prev_rd));
        end
        prev_res = out_result;
        prev_rd  = out_rd;
    endtask

    // One clock: check what the previous edge produced, then drive the next inputs
    task automatic step(input bit v, input logic [31:0] ins, input bit rst, input bit push,
                        input logic [31:0] res, input logic [4:0] rd, input bit ill, input bit ovf);
        exp_t it;
        @(negedge CLK);
        cyc++;
        check_outputs();
        last_rst = rst;
        RST      = rst;
        in_valid = v;
        instr    = ins;
        if (rst) sb.delete();
        if (push) begin
            it.cyc = cyc; it.res = res; it.rd = rd; it.ill = ill; it.ovf = ovf;
            sb.push_back(it);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] res, input logic [4:0] rd);
        step(1'b1, ins, 1'b0, 1'b1, res, rd, 1'b0, 1'b0);
    endtask

    task automatic issue_x(input logic [31:0] ins, input logic [31:0] res, input logic [4:0] rd,
                           input bit ill, input bit ovf);
        step(1'b1, ins, 1'b0, 1'b1, res, rd, ill, ovf);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        // add, then read back R3
        issue(32'h00221820, 32'd3, 5'd3);
        idle();
        issue(enc(5'd3, 5'd0, 5'd9, 5'd0, 6'h20), 32'd3, 5'd9);
        // sub, slt, read back R3
        issue(32'h00221822, 32'hFFFF_FFFF, 5'd3);
        issue(enc(5'd1, 5'd2, 5'd10, 5'd0, 6'h2A), 32'd1, 5'd10);
        issue(enc(5'd3, 5'd0, 5'd9, 5'd0, 6'h20), 32'hFFFF_FFFF, 5'd9);
        // back-to-back dependency, one bubble, read R4
        issue(32'h00221820, 32'd3, 5'd3);
        issue(32'h00632020, 32'd6, 5'd4);
        idle();
        issue(enc(5'd4, 5'd0, 5'd11, 5'd0, 6'h20), 32'd6, 5'd11);
        // R0 destination must not forward or write
        issue(32'h00220020, 32'd3, 5'd0);
        issue(enc(5'd0, 5'd0, 5'd12, 5'd0, 6'h20), 32'd0, 5'd12);
        // illegal funct and illegal opcode, R3 untouched
        issue_x(32'h0022183F, 32'd0, 5'd3, 1'b1, 1'b0);
        issue_x(32'h20221820, 32'd0, 5'd3, 1'b1, 1'b0);
        issue(enc(5'd3, 5'd0, 5'd13, 5'd0, 6'h20), 32'd3, 5'd13);
        // shift to sign bit, overflowing add, dependent read of R6
        issue(32'h00012FC0, 32'h8000_0000, 5'd5);
        issue_x(32'h00A53020, 32'd0, 5'd6, 1'b0, TRAP);
        issue(enc(5'd6, 5'd0, 5'd14, 5'd0, 6'h20), TRAP ? 32'd6 : 32'd0, 5'd14);
        // remaining ALU ops and shift boundaries
        issue(enc(5'd0, 5'd5, 5'd15, 5'd4, 6'h03), 32'hF800_0000, 5'd15);
        issue(enc(5'd0, 5'd5, 5'd16, 5'd4, 6'h02), 32'h0800_0000, 5'd16);
        issue(enc(5'd0, 5'd5, 5'd25, 5'd31, 6'h03), 32'hFFFF_FFFF, 5'd25);
        issue(enc(5'd0, 5'd5, 5'd26, 5'd31, 6'h02), 32'd1, 5'd26);
        issue(enc(5'd1, 5'd2, 5'd17, 5'd0, 6'h27), 32'hFFFF_FFFC, 5'd17);
        issue(enc(5'd7, 5'd2, 5'd18, 5'd0, 6'h26), 32'd5, 5'd18);
        issue(enc(5'd7, 5'd2, 5'd19, 5'd0, 6'h24), 32'd2, 5'd19);
        issue(enc(5'd5, 5'd1, 5'd20, 5'd0, 6'h2B), 32'd0, 5'd20);
        issue(enc(5'd5, 5'd1, 5'd21, 5'd0, 6'h2A), 32'd1, 5'd21);
        issue(enc(5'd1, 5'd2, 5'd22, 5'd0, 6'h23), 32'hFFFF_FFFF, 5'd22);
        issue(enc(5'd7, 5'd8, 5'd23, 5'd0, 6'h21), 32'd15, 5'd23);
        issue_x(enc(5'd5, 5'd1, 5'd24, 5'd0, 6'h22), 32'h7FFF_FFFF, 5'd24, 1'b0, TRAP);
        idle();
        idle();
        // reset with two instructions in flight; neither may retire or write
        step(1'b1, enc(5'd1, 5'd1, 5'd3, 5'd0, 6'h20), 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, enc(5'd2, 5'd2, 5'd1, 5'd0, 6'h20), 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        issue(enc(5'd3, 5'd1, 5'd7, 5'd0, 6'h20), 32'd4, 5'd7);
        issue(enc(5'd1, 5'd0, 5'd8, 5'd0, 6'h20), 32'd1, 5'd8);
        idle();
        idle();
        idle();
        chk("drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
